e_mem_responder: RTL and testbench
==================================

# e_mem_responder

Word-organised synchronous memory that sits at the far end of the E_Mem tile's memory port. It accepts the address/write-data requests that the tile's switch matrix routes out of the fabric and returns read data (`read_data`) to it. A 2-entry response FIFO lets it absorb fabric backpressure. Errors on misaligned or out-of-range addresses are flagged per response.

## Interface
Parameters:
- `DEPTH_LOG2`, 8, log2 of word count; array is 2^DEPTH_LOG2 x 32 bits.

Ports:
- `UserCLK` in 1: sole clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; a request transfers when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address, connected from `addr0`.
- `req_wdata` in 32: write data, connected from `write_data`.
- `req_be` in 4: byte enables for writes; bit i covers `req_wdata[8i+7:8i]`. Ignored for reads.
- `resp_valid` out 1: response at FIFO head.
- `resp_ready` in 1: consumer takes response when `resp_valid && resp_ready`.
- `resp_rdata` out 32: read data, driving `read_data`. 0 for writes and errors.
- `resp_err` out 1: request was misaligned or out of range.

## Operation
- Word index is `req_addr[DEPTH_LOG2+1:2]`.
- Error when `req_addr[1:0] != 0` or any bit of `req_addr[31:DEPTH_LOG2+2]` is set.
- An errored request never touches the array and still produces exactly one response: `resp_err=1`, `resp_rdata=0`.
- Write: each enabled byte is updated at the acceptance edge; disabled bytes keep their value. Response: `resp_err=0`, `resp_rdata=0`.
  - `req_be=0` is a legal no-op write and still gets a response.
- Read: synchronous array read at the acceptance edge; the result is pushed into the FIFO at that same edge.
- One response per accepted request, returned in strict acceptance order.
- Response FIFO: 2 entries, count 0..2.
  - `req_ready = (state==RUN) && (count < 2)`, registered-path only. There is no combinational path from `resp_ready` to `req_ready`.
  - A push and a pop in the same cycle leave count unchanged.
- Read-after-write to the same word in the next cycle returns the new data. No forwarding is needed because the array writes at the edge.
- State machine:
  - `INIT` (only with the macro) transitions to `RUN`.
  - `RUN` is steady state.
  - Without the macro, reset goes straight to `RUN`.

## Timing
- Reset values: `req_ready=0` during reset; `resp_valid=0`, `resp_rdata=0`, `resp_err=0`; FIFO count 0.
- Reset during operation flushes the FIFO and drops any pending responses. Array contents are not cleared unless the macro is enabled.
- Latency: request accepted at edge N produces `resp_valid=1` in the cycle after edge N, when the FIFO was empty.
- Throughput: 1 request/cycle while `resp_ready` is held high.
- Full FIFO (count 2): `req_ready=0` next cycle. It reasserts in the cycle after the first pop.
- Response outputs hold stable while `resp_valid && !resp_ready`.
- `req_ready` rises in the first cycle after `rst` deasserts (no macro).

## Configuration
- `E_MEM_RESP_CLEAR_EN` defined:
  - After `rst` deasserts, the block enters `INIT`.
  - It writes 0 to word k on the k-th cycle, k = 0..2^DEPTH_LOG2-1. `req_ready` stays 0 throughout.
  - It enters `RUN` after the last word; `req_ready` rises in the cycle after.
  - `rst` asserted during `INIT` restarts the sweep from word 0.
- Not defined: no `INIT` state, no sweep counter; array power-up contents are undefined.

## Test plan
- Write `addr=0x10`, `wdata=0xDEADBEEF`, `be=4'hF`; then read `0x10` → write response `rdata=0, err=0`; read response `0xDEADBEEF` one cycle after acceptance.
- Write `0xDEADBEEF` to `0x10`, then write `0x11223344` to `0x10` with `be=4'b0101`, then read → `0xDE22BE44`.
- Read `0x13`, and read `0x400` with `DEPTH_LOG2=8` → both `err=1, rdata=0`; the array is unmodified, checked by a follow-up read.
- `resp_ready=0`, issue 3 back-to-back reads → 2 accepted and `req_ready=0`. Raise `resp_ready` → 3rd accepted one cycle after the first pop; responses arrive in order with data stable while stalled.
- Assert `rst` with 2 responses queued → `resp_valid=0` next cycle, no stale responses after reset.
- With `E_MEM_RESP_CLEAR_EN`, `DEPTH_LOG2=4`: release reset → `req_ready` low for 16 cycles, then high; any read returns 0.

Source files
------------

// File: rtl/e_mem_responder_if.sv
// Request/response bundle between the E_Mem tile's memory port and its responder.
interface e_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/e_mem_responder.sv
// Word-organised memory responder with a 2-entry in-order response FIFO.
// Optional E_MEM_RESP_CLEAR_EN: zero-fill sweep of the array after every reset.
module e_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input logic UserCLK,
  input logic rst,
  e_mem_responder_if.slave bus
);
  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;

`ifdef E_MEM_RESP_CLEAR_EN
  typedef enum logic [0:0] {INIT, RUN} state_t;
  localparam state_t RESET_STATE = INIT;
  logic [DEPTH_LOG2-1:0] sweep;
`else
  typedef enum logic [0:0] {RUN} state_t;
  localparam state_t RESET_STATE = RUN;
`endif

  state_t                state;
  logic [31:0]           mem [WORDS];
  logic [31:0]           fifo_data [2];
  logic                  fifo_err [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  ready;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_err;
  logic                  accept;
  logic                  pop;

  assign idx      = bus.req_addr[DEPTH_LOG2+1:2];
  assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                    ((bus.req_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign accept   = bus.req_valid && ready;
  assign pop      = (count != 2'd0) && bus.resp_ready;

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // req_ready is registered from the next-cycle count so resp_ready never reaches it combinationally.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state  <= RESET_STATE;
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ready  <= 1'b0;
`ifdef E_MEM_RESP_CLEAR_EN
      sweep  <= '0;
`endif
    end else begin
      count <= count_next;
      if (accept) begin
        fifo_data[wr_ptr] <= (addr_err || bus.req_we) ? '0 : mem[idx];
        fifo_err[wr_ptr]  <= addr_err;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
`ifdef E_MEM_RESP_CLEAR_EN
      if (state == INIT) begin
        sweep <= sweep + 1'b1;
        if (sweep == '1) state <= RUN;
        ready <= (sweep == '1);
      end else begin
        ready <= (count_next < 2'd2);
      end
`else
      ready <= (state == RUN) && (count_next < 2'd2);
`endif
    end
  end

  always_ff @(posedge UserCLK) begin
`ifdef E_MEM_RESP_CLEAR_EN
    if (!rst && state == INIT) begin
      mem[sweep] <= '0;
    end else
`endif
    if (!rst && accept && bus.req_we && !addr_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (count != 2'd0);
  assign bus.resp_rdata = bus.resp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.resp_err   = bus.resp_valid && fifo_err[rd_ptr];
endmodule

// File: tb/tb_e_mem_responder.sv
// Directed + randomized bench for e_mem_responder against a word-array/queue model.
module tb_e_mem_responder;
`ifdef E_MEM_RESP_CLEAR_EN
  localparam int unsigned DL = 4;
  localparam int unsigned LOW_EXP = 2 ** DL;
`else
  localparam int unsigned DL = 8;
  localparam int unsigned LOW_EXP = 1;
`endif
  localparam int unsigned WORDS = 2 ** DL;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  logic [31:0] model [WORDS];
  resp_t exp_q[$];

  e_mem_responder_if bus ();

  e_mem_responder #(.DEPTH_LOG2(DL)) dut (
    .UserCLK(clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected response from the address rules; updates the model array on legal writes.
  function automatic resp_t model_apply(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
    resp_t r;
    int unsigned w;
    w = (addr / 4) % WORDS;
    r.err   = (addr % 4 != 0) || (addr >= 4 * WORDS);
    r.rdata = '0;
    if (!r.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        r.rdata = model[w];
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the acceptance edge with req_valid low.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output int waited);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 400) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      check("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
    end else begin
      exp_q.push_back(model_apply(we, addr, wdata, be));
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic monitor();
    bit          prev_stall = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err = 1'b0;
    resp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'b0, bus.resp_valid}, 32'd1);
          check("stall_rdata", bus.resp_rdata, prev_rdata);
          check("stall_err", {31'b0, bus.resp_err}, {31'b0, prev_err});
        end
        if (bus.resp_valid && bus.resp_ready) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", {31'b0, bus.resp_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
          end
        end
        prev_stall = bus.resp_valid && !bus.resp_ready;
        prev_rdata = bus.resp_rdata;
        prev_err   = bus.resp_err;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      step();
      if (rand_ready) bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int waited;
    int low;
    int unsigned sel;
    logic [31:0] a;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.resp_ready = 1'b1;
    for (int unsigned i = 0; i < WORDS; i++) model[i] = '0;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset values and release timing
    repeat (3) step();
    @(negedge clk);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    step();
    rst = 1'b0;
    low = 0;
    @(negedge clk);
    while (!bus.req_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    check("ready_low_cycles", low, LOW_EXP);
    step();

`ifdef E_MEM_RESP_CLEAR_EN
    for (int unsigned i = 0; i < WORDS; i++) send(1'b0, 32'(i * 4), '0, '0, waited);
`endif

    for (int unsigned i = 0; i < WORDS; i++) send(1'b1, 32'(i * 4), $urandom, 4'hF, waited);

    // Write then read: one-cycle read latency
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, waited);
    send(1'b0, 32'h10, '0, '0, waited);
    @(negedge clk);
    check("lat_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("lat_rdata", bus.resp_rdata, 32'hDEADBEEF);
    step();

    send(1'b1, 32'h10, 32'h11223344, 4'b0101, waited);
    send(1'b0, 32'h10, '0, '0, waited);
    @(negedge clk);
    check("be_merge", bus.resp_rdata, 32'hDE22BE44);
    step();

    // Errors: misaligned, out of range, aliasing out-of-range write
    send(1'b0, 32'h13, '0, '0, waited);
    @(negedge clk);
    check("misalign_err", {31'b0, bus.resp_err}, 32'd1);
    check("misalign_rdata", bus.resp_rdata, 32'd0);
    step();
    send(1'b0, 32'h400, '0, '0, waited);
    @(negedge clk);
    check("range_err", {31'b0, bus.resp_err}, 32'd1);
    step();
    send(1'b1, 32'h410, 32'hFFFFFFFF, 4'hF, waited);
    send(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, waited);
    send(1'b1, 32'h14, 32'h0, 4'h0, waited);
    send(1'b0, 32'h10, '0, '0, waited);
    @(negedge clk);
    check("err_no_touch", bus.resp_rdata, 32'hDE22BE44);
    step();

    // Backpressure: FIFO fills at 2, third accepted the cycle after the first pop
    bus.resp_ready = 1'b0;
    send(1'b0, 32'h10, '0, '0, waited);
    send(1'b0, 32'h0, '0, '0, waited);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h4;
    @(negedge clk);
    check("full_ready_low", {31'b0, bus.req_ready}, 32'd0);
    check("full_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    step();
    step();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("pre_pop_ready_low", {31'b0, bus.req_ready}, 32'd0);
    step();
    send(1'b0, 32'h4, '0, '0, waited);
    check("post_pop_wait", waited, 0);

    // Reset with two responses queued
    step();
    bus.resp_ready = 1'b0;
    send(1'b0, 32'h8, '0, '0, waited);
    send(1'b0, 32'hC, '0, '0, waited);
    rst = 1'b1;
    step();
    exp_q.delete();
`ifdef E_MEM_RESP_CLEAR_EN
    for (int unsigned i = 0; i < WORDS; i++) model[i] = '0;
`endif
    @(negedge clk);
    check("rst_flush_valid", {31'b0, bus.resp_valid}, 32'd0);
    step();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("rst_no_stale", {31'b0, bus.resp_valid}, 32'd0);
    step();
    send(1'b0, 32'h10, '0, '0, waited);
    send(1'b0, 32'h8, '0, '0, waited);

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {$urandom_range(0, WORDS - 1), 2'(($urandom_range(1, 3)))};
      else if (sel == 1) a = $urandom | (32'h1 << $urandom_range(31, DL + 2));
      else               a = 32'($urandom_range(0, WORDS - 1) * 4);
      send($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), waited);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready = 1'b0;
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    step();
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    check("drain_valid", {31'b0, bus.resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
